// File: rtl/rmt_egress_fifo.sv
// Store-and-forward AXI-Stream packet FIFO behind the RMT pipeline: only whole packets
// are emitted, packets that do not fit are dropped whole, and the input is never stalled.
module rmt_egress_fifo #(
   parameter int C_AXIS_DATA_WIDTH  = 512,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int FIFO_ADDR_WIDTH    = 6,
   parameter int CNT_WIDTH          = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic                            s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic [CNT_WIDTH-1:0]            pkt_fwd_cnt,
   output logic [CNT_WIDTH-1:0]            pkt_drop_cnt,
   output logic [FIFO_ADDR_WIDTH:0]        fifo_level
);

   localparam int KEEP_W  = C_AXIS_DATA_WIDTH / 8;
   localparam int PTR_W   = FIFO_ADDR_WIDTH + 1;
   localparam int DEPTH   = 1 << FIFO_ADDR_WIDTH;
   localparam int ENTRY_W = C_AXIS_DATA_WIDTH + KEEP_W + C_AXIS_TUSER_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

   state_t                         state;
   logic [ENTRY_W-1:0]             mem [DEPTH];
   logic [PTR_W-1:0]               wr_ptr;
   logic [PTR_W-1:0]               commit_ptr;
   logic [PTR_W-1:0]               rd_ptr;
   logic [PTR_W-1:0]               used;
   logic                           space;
   logic                           wr_en;
   logic                           rd_en;
   logic [ENTRY_W-1:0]             rd_entry;
   logic                           out_valid;
   logic [C_AXIS_DATA_WIDTH-1:0]   out_data;
   logic [KEEP_W-1:0]              out_keep;
   logic [C_AXIS_TUSER_WIDTH-1:0]  out_user;
   logic                           out_last;

   // used never exceeds DEPTH, so its MSB alone tells us the memory is full
   always_comb begin
      used     = wr_ptr - rd_ptr;
      space    = !used[FIFO_ADDR_WIDTH];
      wr_en    = s_axis_tvalid && space && (state != DROP);
      rd_en    = (rd_ptr != commit_ptr) && (!out_valid || m_axis_tready);
      rd_entry = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
   end

   // In IDLE wr_ptr already equals commit_ptr, so the rewind is shared with WRITE
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         commit_ptr   <= '0;
         pkt_drop_cnt <= '0;
      end else if (s_axis_tvalid) begin
         case (state)
            IDLE, WRITE: begin
               if (space) begin
                  wr_ptr <= wr_ptr + PTR_W'(1);
                  if (s_axis_tlast) begin
                     commit_ptr <= wr_ptr + PTR_W'(1);
                     state      <= IDLE;
                  end else begin
                     state <= WRITE;
                  end
               end else begin
                  wr_ptr <= commit_ptr;
                  if (s_axis_tlast) begin
                     pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);
                     state        <= IDLE;
                  end else begin
                     state <= DROP;
                  end
               end
            end
            DROP: begin
               if (s_axis_tlast) begin
                  pkt_drop_cnt <= pkt_drop_cnt + CNT_WIDTH'(1);
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output register is refilled straight from memory whenever it is empty or being drained
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr      <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_keep    <= '0;
         out_user    <= '0;
         out_last    <= 1'b0;
         pkt_fwd_cnt <= '0;
      end else begin
         if (rd_en) begin
            {out_data, out_keep, out_user, out_last} <= rd_entry;
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + PTR_W'(1);
         end else if (m_axis_tready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && m_axis_tready && out_last)
            pkt_fwd_cnt <= pkt_fwd_cnt + CNT_WIDTH'(1);
      end
   end

   assign s_axis_tready = !reset;
   assign m_axis_tvalid = out_valid;
   assign m_axis_tdata  = out_data;
   assign m_axis_tkeep  = out_keep;
   assign m_axis_tuser  = out_user;
   assign m_axis_tlast  = out_last;
   assign fifo_level    = used + {{FIFO_ADDR_WIDTH{1'b0}}, out_valid};

endmodule

// File: tb/tb_rmt_egress_fifo.sv
// Bench for rmt_egress_fifo with a 4-beat buffer: directed scenarios plus random packets
// scored against a queue of expected beats.
module tb_rmt_egress_fifo;

   localparam int DW    = 512;
   localparam int UW    = 128;
   localparam int KW    = DW / 8;
   localparam int AW    = 2;
   localparam int CW    = 32;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] s_axis_tdata = '0;
   logic [KW-1:0] s_axis_tkeep = '0;
   logic [UW-1:0] s_axis_tuser = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic [UW-1:0] m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;
   logic [CW-1:0] pkt_fwd_cnt;
   logic [CW-1:0] pkt_drop_cnt;
   logic [AW:0]   fifo_level;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_pass = 0;
   bit    toggle_ready = 1'b0;
   bit    rand_ready = 1'b0;
   bit    prev_valid = 1'b0;
   bit    prev_ready = 1'b0;
   logic [DW+KW+UW+1:0] prev_bus = '0;

   rmt_egress_fifo #(
      .C_AXIS_DATA_WIDTH  (DW),
      .C_AXIS_TUSER_WIDTH (UW),
      .FIFO_ADDR_WIDTH    (AW),
      .CNT_WIDTH          (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .pkt_fwd_cnt   (pkt_fwd_cnt),
      .pkt_drop_cnt  (pkt_drop_cnt),
      .fifo_level    (fifo_level)
   );

   always #5 clk = ~clk;

   // Downstream ready patterns used by the backpressure and random scenarios
   always @(posedge clk) begin
      #1;
      if (toggle_ready)
         m_axis_tready = ~m_axis_tready;
      else if (rand_ready)
         m_axis_tready = 1'($urandom_range(0, 1));
   end

   // Output monitor: every handshake must match the next expected beat, and a stalled beat must hold
   always @(negedge clk) begin
      beat_t e;
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            n_checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata} !== prev_bus)
               $display("[TB] FAIL axis_stable: got changed outputs (valid=%b last=%b) expected held values",
                        m_axis_tvalid, m_axis_tlast);
            else
               n_pass++;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("[TB] FAIL out_beat: got unexpected beat keep=%h last=%b expected no beat",
                        m_axis_tkeep, m_axis_tlast);
            end else begin
               e = exp_q.pop_front();
               if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep ||
                   m_axis_tuser !== e.user || m_axis_tlast !== e.last)
                  $display("[TB] FAIL out_beat: got keep=%h user=%h last=%b data_ok=%b expected keep=%h user=%h last=%b",
                           m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tdata === e.data,
                           e.keep, e.user, e.last);
               else
                  n_pass++;
            end
         end
         prev_valid = m_axis_tvalid;
         prev_ready = m_axis_tready;
         prev_bus   = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata};
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got simulation timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic beat_t make_beat(input bit last);
      beat_t b;
      for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
      for (int i = 0; i < UW / 32; i++) b.user[i*32 +: 32] = $urandom;
      b.keep = last ? {$urandom, $urandom} : '1;
      b.last = last;
      return b;
   endfunction

   task automatic send_beat(input beat_t b);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tuser  = b.user;
      s_axis_tlast  = b.last;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_packet(input int len, input bit fwd);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b = make_beat(i == len - 1);
         send_beat(b);
         if (fwd) exp_q.push_back(b);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      toggle_ready = 1'b0;
      rand_ready = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      m_axis_tready = 1'b0;
      exp_q.delete();
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (fifo_level == 0 && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      beat_t b;
      bit ok;
      do_reset();
      send_packet(1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         b = make_beat(1'b0);
         send_beat(b);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      s_axis_tvalid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (s_axis_tready !== 1'b0) $display("[TB] FAIL rst_s_tready: got %b expected 0", s_axis_tready);
      else n_pass++;
      n_checks++;
      if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL rst_m_tvalid: got %b expected 0", m_axis_tvalid);
      else n_pass++;
      n_checks++;
      if ({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} !== '0)
         $display("[TB] FAIL rst_m_bus: got keep=%h last=%b expected all zero", m_axis_tkeep, m_axis_tlast);
      else n_pass++;
      n_checks++;
      if (fifo_level !== 0 || pkt_fwd_cnt !== 0 || pkt_drop_cnt !== 0)
         $display("[TB] FAIL rst_status: got level=%0d fwd=%0d drop=%0d expected 0 0 0",
                  fifo_level, pkt_fwd_cnt, pkt_drop_cnt);
      else n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      m_axis_tready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (s_axis_tready !== 1'b1) $display("[TB] FAIL post_rst_s_tready: got %b expected 1", s_axis_tready);
      else n_pass++;
      n_checks++;
      if (fifo_level !== 0 || pkt_fwd_cnt !== 0 || pkt_drop_cnt !== 0)
         $display("[TB] FAIL post_rst_status: got level=%0d fwd=%0d drop=%0d expected 0 0 0",
                  fifo_level, pkt_fwd_cnt, pkt_drop_cnt);
      else n_pass++;
      send_packet(1, 1'b1);
      idle_cycle();
      wait_drain(ok);
      n_checks++;
      if (!ok || pkt_fwd_cnt !== 1) $display("[TB] FAIL post_rst_fwd: got drained=%b fwd=%0d expected 1 1", ok, pkt_fwd_cnt);
      else n_pass++;
   endtask

   task automatic test_single_packet();
      beat_t b0, b1;
      bit    exp_v;
      do_reset();
      m_axis_tready = 1'b1;
      b0 = make_beat(1'b0);
      b1 = make_beat(1'b1);
      b1.keep = 64'h00000000000fffff;
      exp_q.push_back(b0);
      exp_q.push_back(b1);
      send_beat(b0);
      send_beat(b1);
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) idle_cycle();
         @(negedge clk);
         exp_v = (c == 2 || c == 3);
         n_checks++;
         if (m_axis_tvalid !== exp_v) $display("[TB] FAIL single_tvalid_t%0d: got %b expected %b", c, m_axis_tvalid, exp_v);
         else n_pass++;
      end
      n_checks++;
      if (pkt_fwd_cnt !== 1 || exp_q.size() != 0)
         $display("[TB] FAIL single_fwd: got fwd=%0d pending=%0d expected 1 0", pkt_fwd_cnt, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_store_forward();
      beat_t b;
      bit    exp_v;
      do_reset();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         b = make_beat(1'b0);
         exp_q.push_back(b);
         send_beat(b);
      end
      for (int g = 0; g < 5; g++) begin
         idle_cycle();
         @(negedge clk);
         n_checks++;
         if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL sf_gap%0d: got tvalid %b expected 0", g, m_axis_tvalid);
         else n_pass++;
      end
      b = make_beat(1'b1);
      exp_q.push_back(b);
      send_beat(b);
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) idle_cycle();
         @(negedge clk);
         exp_v = (c >= 2 && c <= 4);
         n_checks++;
         if (m_axis_tvalid !== exp_v) $display("[TB] FAIL sf_tvalid_t%0d: got %b expected %b", c, m_axis_tvalid, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_overflow();
      bit ok;
      do_reset();
      send_packet(3, 1'b1);
      send_packet(3, 1'b0);
      idle_cycle();
      @(negedge clk);
      n_checks++;
      if (pkt_drop_cnt !== 1) $display("[TB] FAIL ovf_drop: got %0d expected 1", pkt_drop_cnt);
      else n_pass++;
      n_checks++;
      if (fifo_level !== 3) $display("[TB] FAIL ovf_level: got %0d expected 3", fifo_level);
      else n_pass++;
      @(posedge clk); #1;
      m_axis_tready = 1'b1;
      wait_drain(ok);
      n_checks++;
      if (!ok || pkt_fwd_cnt !== 1 || pkt_drop_cnt !== 1)
         $display("[TB] FAIL ovf_after: got drained=%b fwd=%0d drop=%0d expected 1 1 1", ok, pkt_fwd_cnt, pkt_drop_cnt);
      else n_pass++;
   endtask

   task automatic test_oversize();
      bit ok;
      do_reset();
      m_axis_tready = 1'b1;
      send_packet(DEPTH + 1, 1'b0);
      idle_cycle();
      @(negedge clk);
      n_checks++;
      if (pkt_drop_cnt !== 1 || fifo_level !== 0 || m_axis_tvalid !== 1'b0)
         $display("[TB] FAIL oversize: got drop=%0d level=%0d tvalid=%b expected 1 0 0",
                  pkt_drop_cnt, fifo_level, m_axis_tvalid);
      else n_pass++;
      send_packet(1, 1'b1);
      idle_cycle();
      wait_drain(ok);
      n_checks++;
      if (!ok || pkt_fwd_cnt !== 1) $display("[TB] FAIL oversize_next: got drained=%b fwd=%0d expected 1 1", ok, pkt_fwd_cnt);
      else n_pass++;
   endtask

   task automatic test_back_pressure();
      bit ok;
      do_reset();
      toggle_ready = 1'b1;
      send_packet(2, 1'b1);
      send_packet(2, 1'b1);
      idle_cycle();
      wait_drain(ok);
      n_checks++;
      if (!ok || pkt_fwd_cnt !== 2) $display("[TB] FAIL bp_fwd: got drained=%b fwd=%0d expected 1 2", ok, pkt_fwd_cnt);
      else n_pass++;
      toggle_ready = 1'b0;
   endtask

   task automatic test_random_packets();
      bit ok;
      int len;
      int exp_fwd = 0;
      int exp_drop = 0;
      do_reset();
      rand_ready = 1'b1;
      for (int p = 0; p < 16; p++) begin
         len = $urandom_range(1, DEPTH + 2);
         if (len <= DEPTH) exp_fwd++;
         else exp_drop++;
         send_packet(len, len <= DEPTH);
         idle_cycle();
         repeat ($urandom_range(0, 3)) idle_cycle();
         wait_drain(ok);
         n_checks++;
         if (!ok) $display("[TB] FAIL rand_drain_p%0d: got level=%0d pending=%0d expected 0 0", p, fifo_level, exp_q.size());
         else n_pass++;
      end
      n_checks++;
      if (pkt_fwd_cnt !== CW'(exp_fwd) || pkt_drop_cnt !== CW'(exp_drop))
         $display("[TB] FAIL rand_counts: got fwd=%0d drop=%0d expected %0d %0d",
                  pkt_fwd_cnt, pkt_drop_cnt, exp_fwd, exp_drop);
      else n_pass++;
      rand_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_store_forward();
      test_overflow();
      test_oversize();
      test_back_pressure();
      test_random_packets();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
